// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge
//   Couples a ZPU soft core to the HPS SD-card block service. It provides a
//   dual-port sector buffer, the LBA register, a block read/write request
//   handshake with a timeout, and mount-event status capture.
//
// Ports
//   CLK, RESET_N      : clock and asynchronous active-low reset
//   ZPU_OUT2          : [0] lba-select, [1] block_rd, [2] block_wr, [5:3] drive
//   ZPU_OUT3          : write data (LBA or buffer byte in [7:0])
//   ZPU_DATA_WR       : write strobe. Its rising edge is detected after 2 flops.
//   ZPU_DATA_RD       : read strobe. Its falling edge advances the pointer.
//   ZPU_IO_WR         : clears the buffer pointer
//   ZPU_IN2           : {readonly, filetype[1:0], fileno[2:0], mount toggle, io_done}
//   ZPU_IN3           : file size (lba-select=1) or buffer byte at the pointer
//   IO_ERR            : last block operation failed (bad drive or timeout)
//   sd_lba, sd_rd, sd_wr, sd_ack : HPS block request handshake
//   sd_buff_*         : HPS side of the sector buffer
//   img_mounted, img_readonly, img_size, ioctl_index : mount notification

module zpu_sd_bridge #(
    parameter int unsigned          NUM_DRV = 3,
    parameter int unsigned          BUF_AW  = 9,
    parameter int unsigned          TMO_W   = 24,
    parameter logic [NUM_DRV-1:0]   RO_MASK = '0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [31:0]         ZPU_OUT2,
    input  logic [31:0]         ZPU_OUT3,
    input  logic                ZPU_DATA_WR,
    input  logic                ZPU_DATA_RD,
    input  logic                ZPU_IO_WR,
    output logic [7:0]          ZPU_IN2,
    output logic [31:0]         ZPU_IN3,
    output logic                IO_ERR,
    output logic [31:0]         sd_lba,
    output logic [NUM_DRV-1:0]  sd_rd,
    output logic [NUM_DRV-1:0]  sd_wr,
    input  logic                sd_ack,
    input  logic [BUF_AW-1:0]   sd_buff_addr,
    input  logic [7:0]          sd_buff_dout,
    output logic [7:0]          sd_buff_din,
    input  logic                sd_buff_wr,
    input  logic [NUM_DRV-1:0]  img_mounted,
    input  logic                img_readonly,
    input  logic [63:0]         img_size,
    input  logic [7:0]          ioctl_index
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    state_t             r_state, w_state_nxt;

    logic [7:0]         r_mem [0:(1<<BUF_AW)-1];
    logic [7:0]         r_qb;
    logic [BUF_AW-1:0]  r_ptr;
    logic [2:0]         r_dwr_sync;
    logic               r_drd_q, r_brd_q, r_bwr_q, r_mnt_q;
    logic               r_wr_inc;
    logic [2:0]         r_drv;
    logic               r_is_rd;
    logic               r_io_done, r_io_err;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_mtog, r_ro;
    logic [2:0]         r_fileno;
    logic [1:0]         r_ftype;
    logic [31:0]        r_fsize;

    logic               w_lba_sel, w_blk_rd, w_blk_wr;
    logic [2:0]         w_drive;
    logic               w_wr_edge, w_rd_fall, w_brd_rise, w_bwr_rise;
    logic               w_mnt_any, w_mnt_rise;
    logic               w_bad_drv;
    logic [2:0]         w_mnt_idx;
    logic               w_mnt_rmask;
    logic [NUM_DRV-1:0] w_drv_vec;
    logic               w_start, w_clr_sts, w_set_done, w_set_err, w_tmo_clr, w_tmo_inc;
    logic               w_unused;

    assign w_lba_sel  = ZPU_OUT2[0];
    assign w_blk_rd   = ZPU_OUT2[1];
    assign w_blk_wr   = ZPU_OUT2[2];
    assign w_drive    = ZPU_OUT2[5:3];

    assign w_wr_edge  = r_dwr_sync[1] & ~r_dwr_sync[2];
    assign w_rd_fall  = r_drd_q & ~ZPU_DATA_RD;
    assign w_brd_rise = w_blk_rd & ~r_brd_q;
    assign w_bwr_rise = w_blk_wr & ~r_bwr_q;
    assign w_mnt_any  = |img_mounted;
    assign w_mnt_rise = w_mnt_any & ~r_mnt_q;
    assign w_bad_drv  = ({1'b0, w_drive} >= 4'(NUM_DRV));
    assign w_drv_vec  = NUM_DRV'(1) << r_drv;

    assign w_unused   = ^{ZPU_OUT2[31:6], img_size[63:32], ioctl_index[5:0]};

    assign ZPU_IN2 = {r_ro, r_ftype, r_fileno, r_mtog, r_io_done};
    assign ZPU_IN3 = w_lba_sel ? r_fsize : {24'h0, r_qb};
    assign IO_ERR  = r_io_err;

    // Scan from the top down so the lowest mounted slot is the last one written.
    always_comb begin
        w_mnt_idx   = '0;
        w_mnt_rmask = 1'b0;
        for (int unsigned i = NUM_DRV; i > 0; i--) begin
            if (img_mounted[i-1]) begin
                w_mnt_idx   = 3'(i - 1);
                w_mnt_rmask = RO_MASK[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // The request lines decode from the state, so an asynchronous reset drops them immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_clr_sts   = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        sd_rd       = '0;
        sd_wr       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_brd_rise || w_bwr_rise) begin
                    w_clr_sts = 1'b1;
                    if (w_bad_drv) begin
                        w_state_nxt = S_DONE;
                        w_set_done  = 1'b1;
                        w_set_err   = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_start     = 1'b1;
                        w_tmo_clr   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (r_is_rd) sd_rd = w_drv_vec;
                else         sd_wr = w_drv_vec;
                if (sd_ack) begin
                    sd_rd       = '0;
                    sd_wr       = '0;
                    w_state_nxt = S_XFER;
                    w_tmo_clr   = 1'b1;
                end else if (r_tmo == '1) begin
                    w_state_nxt = S_DONE;
                    w_set_done  = 1'b1;
                    w_set_err   = 1'b1;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    w_state_nxt = S_DONE;
                    w_set_done  = 1'b1;
                end else if (r_tmo == '1) begin
                    w_state_nxt = S_DONE;
                    w_set_done  = 1'b1;
                    w_set_err   = 1'b1;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dwr_sync  <= '0;
            r_drd_q     <= 1'b0;
            r_brd_q     <= 1'b0;
            r_bwr_q     <= 1'b0;
            r_mnt_q     <= 1'b0;
            r_wr_inc    <= 1'b0;
            r_ptr       <= '0;
            sd_lba      <= '0;
            r_drv       <= '0;
            r_is_rd     <= 1'b0;
            r_io_done   <= 1'b0;
            r_io_err    <= 1'b0;
            r_tmo       <= '0;
            r_mtog      <= 1'b0;
            r_fileno    <= '0;
            r_ftype     <= '0;
            r_ro        <= 1'b0;
            r_fsize     <= '0;
            r_qb        <= '0;
            sd_buff_din <= '0;
        end else begin
            r_dwr_sync <= {r_dwr_sync[1:0], ZPU_DATA_WR};
            r_drd_q    <= ZPU_DATA_RD;
            r_brd_q    <= w_blk_rd;
            r_bwr_q    <= w_blk_wr;
            r_mnt_q    <= w_mnt_any;

            if (w_wr_edge && w_lba_sel) sd_lba <= ZPU_OUT3;
            // The byte lands at the current pointer; the pointer moves one cycle later.
            r_wr_inc <= w_wr_edge & ~w_lba_sel;

            if (ZPU_IO_WR)                  r_ptr <= '0;
            else if (r_wr_inc || w_rd_fall) r_ptr <= r_ptr + 1'b1;

            if (w_start) begin
                r_drv   <= w_drive;
                r_is_rd <= w_brd_rise;
            end
            if (w_clr_sts) begin
                r_io_done <= 1'b0;
                r_io_err  <= 1'b0;
            end
            if (w_set_done) r_io_done <= 1'b1;
            if (w_set_err)  r_io_err  <= 1'b1;

            if (w_tmo_clr)      r_tmo <= '0;
            else if (w_tmo_inc) r_tmo <= r_tmo + 1'b1;

            if (w_mnt_rise) begin
                r_fileno <= w_mnt_idx;
                r_ftype  <= ioctl_index[7:6];
                r_ro     <= img_readonly | w_mnt_rmask;
                r_fsize  <= img_size[31:0];
                r_mtog   <= ~r_mtog;
            end

            r_qb        <= r_mem[r_ptr];
            sd_buff_din <= r_mem[sd_buff_addr];
        end
    end

    // Buffer storage keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (sd_buff_wr) r_mem[sd_buff_addr] <= sd_buff_dout;
        if (w_wr_edge && !w_lba_sel) r_mem[r_ptr] <= ZPU_OUT3[7:0];
    end

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Testbench for zpu_sd_bridge. Instance A uses the default timeout width.
// Instance B uses TMO_W=4 and RO_MASK=3'b100. The two instances share their
// inputs, and each is held in reset while the other one is being exercised.

module tb_zpu_sd_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] out2, out3;
    logic        dwr, drd, iowr, ack, bwr, mro;
    logic [8:0]  baddr;
    logic [7:0]  bdout, ioidx;
    logic [2:0]  mnt;
    logic [63:0] isize;

    logic [7:0]  a_in2, b_in2, a_din, b_din;
    logic [31:0] a_in3, b_in3, a_lba, b_lba;
    logic        a_err, b_err;
    logic [2:0]  a_rd, a_wr, b_rd, b_wr;

    int checks = 0;
    int errors = 0;

    zpu_sd_bridge #(.NUM_DRV(3), .BUF_AW(9), .TMO_W(24), .RO_MASK(3'b000)) u_a (
        .CLK(clk), .RESET_N(rst_a), .ZPU_OUT2(out2), .ZPU_OUT3(out3),
        .ZPU_DATA_WR(dwr), .ZPU_DATA_RD(drd), .ZPU_IO_WR(iowr),
        .ZPU_IN2(a_in2), .ZPU_IN3(a_in3), .IO_ERR(a_err),
        .sd_lba(a_lba), .sd_rd(a_rd), .sd_wr(a_wr), .sd_ack(ack),
        .sd_buff_addr(baddr), .sd_buff_dout(bdout), .sd_buff_din(a_din), .sd_buff_wr(bwr),
        .img_mounted(mnt), .img_readonly(mro), .img_size(isize), .ioctl_index(ioidx)
    );

    zpu_sd_bridge #(.NUM_DRV(3), .BUF_AW(9), .TMO_W(4), .RO_MASK(3'b100)) u_b (
        .CLK(clk), .RESET_N(rst_b), .ZPU_OUT2(out2), .ZPU_OUT3(out3),
        .ZPU_DATA_WR(dwr), .ZPU_DATA_RD(drd), .ZPU_IO_WR(iowr),
        .ZPU_IN2(b_in2), .ZPU_IN3(b_in3), .IO_ERR(b_err),
        .sd_lba(b_lba), .sd_rd(b_rd), .sd_wr(b_wr), .sd_ack(ack),
        .sd_buff_addr(baddr), .sd_buff_dout(bdout), .sd_buff_din(b_din), .sd_buff_wr(bwr),
        .img_mounted(mnt), .img_readonly(mro), .img_size(isize), .ioctl_index(ioidx)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    task automatic zpu_wr(input logic [31:0] d, input logic lba);
        out2[0] = lba;
        out3    = d;
        dwr     = 1'b1;
        cyc(3);
        dwr     = 1'b0;
        cyc(3);
    endtask

    task automatic test_reset;
        rst_a = 1'b0; rst_b = 1'b0;
        out2 = '0; out3 = '0; dwr = 0; drd = 0; iowr = 0; ack = 0; bwr = 0;
        baddr = '0; bdout = '0; mnt = '0; mro = 0; isize = '0; ioidx = '0;
        #3;
        checks++; if (a_in2 !== 8'h00) begin errors++; $display("FAIL reset_a_in2 got %h exp 00", a_in2); end
        checks++; if (a_in3 !== 32'h0) begin errors++; $display("FAIL reset_a_in3 got %h exp 0", a_in3); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_err got %b exp 0", a_err); end
        checks++; if (a_lba !== 32'h0) begin errors++; $display("FAIL reset_a_lba got %h exp 0", a_lba); end
        checks++; if ({a_rd, a_wr} !== 6'b0) begin errors++; $display("FAIL reset_a_req got %b exp 0", {a_rd, a_wr}); end
        checks++; if ({b_in2, b_err, b_rd, b_wr} !== 15'b0) begin errors++; $display("FAIL reset_b got %h exp 0", {b_in2, b_err, b_rd, b_wr}); end
        cyc(1);
        rst_a = 1'b1;
        cyc(1);
    endtask

    task automatic test_read;
        zpu_wr(32'h0000_0123, 1'b1);
        checks++; if (a_lba !== 32'h0000_0123) begin errors++; $display("FAIL rd_lba got %h exp 00000123", a_lba); end
        out2 = 32'h0B;
        cyc(1);
        checks++; if (a_rd !== 3'b010) begin errors++; $display("FAIL rd_req got %b exp 010", a_rd); end
        out2 = 32'h0F;                        // block_wr rising while in REQ
        cyc(2);
        checks++; if (a_rd !== 3'b010) begin errors++; $display("FAIL rd_req_hold got %b exp 010", a_rd); end
        checks++; if (a_wr !== 3'b000) begin errors++; $display("FAIL rd_ignore_wr got %b exp 000", a_wr); end
        ack = 1'b1;
        cyc(1);
        checks++; if (a_rd !== 3'b000) begin errors++; $display("FAIL rd_ack_clr got %b exp 000", a_rd); end
        for (int i = 0; i < 512; i++) begin
            baddr = 9'(i); bdout = pat(i); bwr = 1'b1;
            cyc(1);
        end
        bwr = 1'b0;
        cyc(2);
        checks++; if (a_in2[0] !== 1'b0) begin errors++; $display("FAIL rd_done_early got %b exp 0", a_in2[0]); end
        ack = 1'b0;
        cyc(1);
        checks++; if (a_in2[0] !== 1'b1) begin errors++; $display("FAIL rd_done got %b exp 1", a_in2[0]); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", a_err); end
        out2 = 32'h0;
        iowr = 1'b1; cyc(1); iowr = 1'b0; cyc(1);
        checks++; if (a_in3 !== {24'h0, pat(0)}) begin errors++; $display("FAIL rd_byte0 got %h exp %h", a_in3, pat(0)); end
        for (int i = 1; i <= 512; i++) begin
            drd = 1'b1; cyc(1);
            drd = 1'b0; cyc(2);
            checks++;
            if (a_in3 !== {24'h0, pat(i % 512)}) begin
                errors++; $display("FAIL rd_byte%0d got %h exp %h", i, a_in3, pat(i % 512));
            end
        end
        drd = 1'b1; cyc(1);
        drd = 1'b0; iowr = 1'b1; cyc(1);
        iowr = 1'b0; cyc(1);
        checks++; if (a_in3 !== {24'h0, pat(0)}) begin errors++; $display("FAIL rd_iowr_prio got %h exp %h", a_in3, pat(0)); end
    endtask

    task automatic test_write;
        logic [7:0] vals [4];
        vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        out2 = 32'h0;
        iowr = 1'b1; cyc(1); iowr = 1'b0; cyc(1);
        for (int k = 0; k < 4; k++) zpu_wr({24'h0, vals[k]}, 1'b0);
        out2 = 32'h04;
        cyc(1);
        checks++; if (a_wr !== 3'b001) begin errors++; $display("FAIL wr_req got %b exp 001", a_wr); end
        checks++; if (a_rd !== 3'b000) begin errors++; $display("FAIL wr_no_rd got %b exp 000", a_rd); end
        checks++; if (a_in2[0] !== 1'b0) begin errors++; $display("FAIL wr_done_clr got %b exp 0", a_in2[0]); end
        ack = 1'b1;
        cyc(1);
        checks++; if (a_wr !== 3'b000) begin errors++; $display("FAIL wr_ack_clr got %b exp 000", a_wr); end
        for (int k = 0; k < 4; k++) begin
            baddr = 9'(k);
            cyc(1);
            checks++; if (a_din !== vals[k]) begin errors++; $display("FAIL wr_porta%0d got %h exp %h", k, a_din, vals[k]); end
        end
        ack = 1'b0;
        cyc(1);
        checks++; if (a_in2[0] !== 1'b1) begin errors++; $display("FAIL wr_done got %b exp 1", a_in2[0]); end
        out2 = 32'h0;
        cyc(2);
    endtask

    task automatic test_bad_drive;
        rst_a = 1'b0; out2 = 32'h0; ack = 1'b0;
        rst_b = 1'b1;
        cyc(2);
        out2 = 32'h2A;                        // block_rd, drive 5
        cyc(1);
        checks++; if (b_rd !== 3'b000) begin errors++; $display("FAIL bad_no_req1 got %b exp 000", b_rd); end
        cyc(1);
        checks++; if (b_rd !== 3'b000) begin errors++; $display("FAIL bad_no_req2 got %b exp 000", b_rd); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", b_err); end
        checks++; if (b_in2[0] !== 1'b1) begin errors++; $display("FAIL bad_done got %b exp 1", b_in2[0]); end
        out2 = 32'h0;
        cyc(2);
    endtask

    task automatic test_timeout;
        out2 = 32'h02;                        // block_rd, drive 0
        cyc(1);
        checks++; if (b_rd !== 3'b001) begin errors++; $display("FAIL tmo_req got %b exp 001", b_rd); end
        checks++; if ({b_err, b_in2[0]} !== 2'b00) begin errors++; $display("FAIL tmo_sts_clr got %b exp 00", {b_err, b_in2[0]}); end
        cyc(15);
        checks++; if (b_rd !== 3'b001) begin errors++; $display("FAIL tmo_still_req got %b exp 001", b_rd); end
        checks++; if (b_in2[0] !== 1'b0) begin errors++; $display("FAIL tmo_early_done got %b exp 0", b_in2[0]); end
        cyc(1);
        checks++; if (b_rd !== 3'b000) begin errors++; $display("FAIL tmo_req_clr got %b exp 000", b_rd); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", b_err); end
        checks++; if (b_in2[0] !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", b_in2[0]); end
        out2 = 32'h0;
        cyc(2);
    endtask

    task automatic test_mount;
        out2 = 32'h01;
        mnt = 3'b100; mro = 1'b0; isize = 64'd92176; ioidx = 8'h40;
        cyc(2);
        checks++; if (b_in2[4:2] !== 3'd2) begin errors++; $display("FAIL mnt_fileno got %0d exp 2", b_in2[4:2]); end
        checks++; if (b_in2[7] !== 1'b1) begin errors++; $display("FAIL mnt_ro got %b exp 1", b_in2[7]); end
        checks++; if (b_in2[6:5] !== 2'b01) begin errors++; $display("FAIL mnt_ftype got %b exp 01", b_in2[6:5]); end
        checks++; if (b_in2[1] !== 1'b1) begin errors++; $display("FAIL mnt_toggle got %b exp 1", b_in2[1]); end
        checks++; if (b_in3 !== 32'd92176) begin errors++; $display("FAIL mnt_size got %0d exp 92176", b_in3); end
        mnt = 3'b000;
        cyc(2);
    endtask

    task automatic test_mount_xfer_reset;
        rst_b = 1'b0; out2 = 32'h0; ack = 1'b0; mnt = 3'b000;
        rst_a = 1'b1;
        cyc(1);
        zpu_wr(32'h0000_0055, 1'b1);
        out2 = 32'h13;                        // lba-select, block_rd, drive 2
        cyc(1);
        checks++; if (a_rd !== 3'b100) begin errors++; $display("FAIL mx_req got %b exp 100", a_rd); end
        ack = 1'b1;
        cyc(1);
        mnt = 3'b110; mro = 1'b1; isize = 64'h1_0000_ABCD; ioidx = 8'hC0;
        cyc(2);
        checks++; if (a_in2 !== 8'b1110_0110) begin errors++; $display("FAIL mx_in2 got %b exp 11100110", a_in2); end
        checks++; if (a_in3 !== 32'h0000_ABCD) begin errors++; $display("FAIL mx_size got %h exp 0000abcd", a_in3); end
        checks++; if ({a_rd, a_wr, a_err} !== 7'b0) begin errors++; $display("FAIL mx_state got %b exp 0", {a_rd, a_wr, a_err}); end
        checks++; if (a_lba !== 32'h55) begin errors++; $display("FAIL mx_lba got %h exp 55", a_lba); end
        #2 rst_a = 1'b0;
        #1;
        checks++; if (a_in2 !== 8'h00) begin errors++; $display("FAIL mx_rst_in2 got %h exp 00", a_in2); end
        checks++; if (a_in3 !== 32'h0) begin errors++; $display("FAIL mx_rst_in3 got %h exp 0", a_in3); end
        checks++; if ({a_lba, a_err, a_rd, a_wr} !== 39'b0) begin errors++; $display("FAIL mx_rst_regs got %h exp 0", {a_lba, a_err, a_rd, a_wr}); end
        out2 = 32'h0; ack = 1'b0; mnt = 3'b000;
        @(negedge clk);
        rst_a = 1'b1;
        cyc(1);
        out2 = 32'h0A;                        // block_rd, drive 1
        cyc(1);
        checks++; if (a_rd !== 3'b010) begin errors++; $display("FAIL mx_idle_req got %b exp 010", a_rd); end
        #2 rst_a = 1'b0;
        #1;
        checks++; if (a_rd !== 3'b000) begin errors++; $display("FAIL mx_rst_drop got %b exp 000", a_rd); end
        @(negedge clk);
        out2 = 32'h0;
        rst_a = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bad_drive();
        test_timeout();
        test_mount();
        test_mount_xfer_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zpu_sd_bridge.md
ZPU_SD_BRIDGE -- requirements
Module: zpu_sd_bridge

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_DRV, 3, drive slots, range 1..8.
REQ-002 The block SHALL have parameter BUF_AW, 9, sector-buffer address width (2^BUF_AW bytes).
REQ-003 The block SHALL have parameter TMO_W, 24, timeout counter width.
REQ-004 The block SHALL have parameter RO_MASK, 0, a NUM_DRV-bit mask of slots forced read-only.
REQ-005 The block SHALL have these ports (name, direction, width, meaning): CLK, in, 1, the only clock; RESET_N, in, 1, asynchronous active-low reset.
REQ-006 ZPU ports: ZPU_OUT2 in 32 ([0] lba-select, [1] block_rd, [2] block_wr, [5:3] drive); ZPU_OUT3 in 32 write data; ZPU_DATA_WR in 1; ZPU_DATA_RD in 1; ZPU_IO_WR in 1 (pointer clear).
REQ-007 ZPU outputs: ZPU_IN2 out 8 ([0] io_done, [1] mount toggle, [4:2] fileno, [6:5] filetype, [7] readonly); ZPU_IN3 out 32; IO_ERR out 1.
REQ-008 SD ports: sd_lba out 32; sd_rd out NUM_DRV; sd_wr out NUM_DRV; sd_ack in 1; sd_buff_addr in BUF_AW; sd_buff_dout in 8; sd_buff_din out 8; sd_buff_wr in 1.
REQ-009 Mount ports: img_mounted in NUM_DRV; img_readonly in 1; img_size in 64; ioctl_index in 8.

Function
REQ-010 The sector buffer SHALL be a true dual-port RAM with 2^BUF_AW bytes: port A on the sd_buff_* signals, port B on the ZPU pointer, with 1-cycle read latency on both ports.
REQ-011 The ZPU write edge SHALL be the rising edge of ZPU_DATA_WR seen after a 2-flop delay: if lba-select is set, sd_lba <= ZPU_OUT3; otherwise ZPU_OUT3[7:0] is written at the pointer, and the pointer increments on the following cycle.
REQ-012 The falling edge of ZPU_DATA_RD SHALL increment the pointer by 1.
REQ-013 The pointer SHALL wrap modulo 2^BUF_AW.
REQ-014 ZPU_IO_WR high SHALL force the pointer to 0, taking priority over any increment in the same cycle.
REQ-015 ZPU_IN3 SHALL equal the current file size when lba-select is set, else the zero-extended buffer byte at the pointer.
REQ-016 The FSM SHALL have states IDLE, REQ, XFER and DONE.
REQ-017 In IDLE, a rising edge of block_rd (or of block_wr) SHALL clear io_done and IO_ERR and go to REQ; in REQ, bit [drive] of sd_rd (or sd_wr) is held at 1.
REQ-018 A simultaneous rising edge of block_rd and block_wr SHALL be treated as a read.
REQ-019 A drive number >= NUM_DRV SHALL go directly to DONE with IO_ERR=1, asserting no request.
REQ-020 In REQ, sd_ack=1 SHALL clear all sd_rd and sd_wr bits and go to XFER.
REQ-021 In XFER, sd_ack falling SHALL go to DONE.
REQ-022 DONE SHALL set io_done=1 and return to IDLE after 1 cycle.
REQ-023 Block edges arriving outside IDLE SHALL be ignored.
REQ-024 The timeout counter SHALL reset on entry to REQ and to XFER, and count in those states.
REQ-025 When the timeout counter reaches all-ones, the block SHALL clear sd_rd and sd_wr, set IO_ERR=1, and go to DONE.
REQ-026 A mount event is a rising edge of |img_mounted. On it: fileno <= lowest set index; filetype <= ioctl_index[7:6]; readonly <= img_readonly | RO_MASK[index]; file size <= img_size[31:0]; mount toggle inverts.
REQ-027 Mount events SHALL be processed in any FSM state without disturbing a transfer in progress.

Reset
REQ-028 While RESET_N=0, the block SHALL asynchronously clear: FSM to IDLE, sd_rd=0, sd_wr=0, sd_lba=0, pointer=0, io_done=0, IO_ERR=0, mount toggle=0, fileno=0, filetype=0, readonly=0, file size=0, timeout=0, and all edge-detect flops.
REQ-029 Buffer contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-transfer SHALL drop the request immediately; on release the FSM starts in IDLE.

Verification
REQ-031 Read: ZPU writes lba 0x00000123, then a block_rd edge with drive=1 -> sd_lba=0x123, sd_rd=3'b010 until sd_ack; the HPS writes 512 bytes; io_done=1 one cycle after sd_ack falls; 512 ZPU_DATA_RD pulses return the bytes in order and the pointer wraps to 0.
REQ-032 Write: ZPU_IO_WR, then 4 data writes AA,BB,CC,DD, then a block_wr edge with drive=0 -> sd_wr=3'b001; HPS port A reads AA,BB,CC,DD at addresses 0..3.
REQ-033 Timeout: TMO_W=4, block_rd edge with no sd_ack -> sd_rd clears and IO_ERR=1, io_done=1 after 15 counting cycles.
REQ-034 Bad drive: drive=5 with NUM_DRV=3 -> no sd_rd bit asserts; IO_ERR=1 and io_done=1 within 2 cycles.
REQ-035 Mount: img_mounted=3'b100, RO_MASK=3'b100, img_readonly=0, img_size=92176 -> fileno=2, readonly=1, ZPU_IN3=92176 with lba-select set, mount toggle flips.
REQ-036 Mount during XFER plus RESET_N pulled low mid-XFER -> mount fields update without a state change; the reset returns all outputs to the REQ-028 values asynchronously.
